// File: rtl/decode_stage_hz_if.sv
// ---------------------------------------------------------------------------
// decode_stage_hz_if
// Bundles the decode-stage signals: the IF/ID inputs, writeback and memory
// stage feedback, execute destination, and the ID/EX register outputs.
//   slave  : view used by decode_stage_hz (feedback in, ID/EX + hazards out)
//   master : view used by whatever drives the stage (pipeline or bench)
// ---------------------------------------------------------------------------
interface decode_stage_hz_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int CNTW = 16
);
    localparam int RB = $clog2(NREG);

    // inputs to decode
    logic            clr;
    logic [31:0]     instrD;
    logic [XLEN-1:0] pcplus4D;
    logic            regwriteW;
    logic [RB-1:0]   writeregW;
    logic [XLEN-1:0] resultW;
    logic            regwriteM;
    logic            memtoregM;
    logic [RB-1:0]   writeregM;
    logic [XLEN-1:0] aluoutM;
    logic [RB-1:0]   writeregE;

    // outputs from decode
    logic            stallF;
    logic            stallD;
    logic            pcsrcD;
    logic            jumpD;
    logic [XLEN-1:0] pcbranchD;
    logic [XLEN-1:0] pcjumpD;
    logic            validE;
    logic            regwriteE;
    logic            memtoregE;
    logic            memwriteE;
    logic            alusrcE;
    logic            regdstE;
    logic [2:0]      alucontrolE;
    logic [XLEN-1:0] rd1E;
    logic [XLEN-1:0] rd2E;
    logic [XLEN-1:0] signimmE;
    logic [RB-1:0]   rsE;
    logic [RB-1:0]   rtE;
    logic [RB-1:0]   rdE;
    logic [CNTW-1:0] stallcount;

    modport slave (
        input  clr, instrD, pcplus4D, regwriteW, writeregW, resultW,
               regwriteM, memtoregM, writeregM, aluoutM, writeregE,
        output stallF, stallD, pcsrcD, jumpD, pcbranchD, pcjumpD,
               validE, regwriteE, memtoregE, memwriteE, alusrcE, regdstE,
               alucontrolE, rd1E, rd2E, signimmE, rsE, rtE, rdE, stallcount
    );

    modport master (
        output clr, instrD, pcplus4D, regwriteW, writeregW, resultW,
               regwriteM, memtoregM, writeregM, aluoutM, writeregE,
        input  stallF, stallD, pcsrcD, jumpD, pcbranchD, pcjumpD,
               validE, regwriteE, memtoregE, memwriteE, alusrcE, regdstE,
               alucontrolE, rd1E, rd2E, signimmE, rsE, rtE, rdE, stallcount
    );
endinterface

// File: rtl/decode_stage_hz.sv
// ---------------------------------------------------------------------------
// decode_stage_hz
// Decode stage of the 5-stage MIPS-subset pipeline: register file with
// writeback bypass, main control decode, beq/bne resolution with operand
// forwarding from M, branch/jump targets, load-use and branch-dependency
// stall detection, the ID/EX register (with valid bit) and a saturating
// stall-cycle counter.
// Ports:
//   clk   : clock, all state on the rising edge
//   rstn  : asynchronous active-low reset
//   bus   : decode_stage_hz_if.slave (all datapath/control signals)
// ---------------------------------------------------------------------------
module decode_stage_hz #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rstn,
    decode_stage_hz_if.slave bus
);
    localparam int RB = $clog2(NREG);

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic [2:0] alucontrol;
    } ctrl_t;

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [RB-1:0]   rs;
        logic [RB-1:0]   rt;
        logic [RB-1:0]   rd;
    } idex_t;

    // ---------------- field extraction ----------------
    logic [5:0]      w_op;
    logic [5:0]      w_funct;
    logic [RB-1:0]   w_rsD;
    logic [RB-1:0]   w_rtD;
    logic [RB-1:0]   w_rdD;
    logic [XLEN-1:0] w_signimm;

    assign w_op      = bus.instrD[31:26];
    assign w_funct   = bus.instrD[5:0];
    // size casts zero-extend or truncate the 5-bit fields to RB bits
    assign w_rsD     = RB'(bus.instrD[25:21]);
    assign w_rtD     = RB'(bus.instrD[20:16]);
    assign w_rdD     = RB'(bus.instrD[15:11]);
    assign w_signimm = {{(XLEN-16){bus.instrD[15]}}, bus.instrD[15:0]};

    // ---------------- main decoder ----------------
    ctrl_t w_ctrl;
    logic  w_branch;
    logic  w_isbne;
    logic  w_jump;

    always_comb begin
        w_ctrl   = '0;
        w_branch = 1'b0;
        w_isbne  = 1'b0;
        w_jump   = 1'b0;
        case (w_op)
            6'b000000: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.regdst   = 1'b1;
                case (w_funct)
                    6'b100000: w_ctrl.alucontrol = 3'b010;
                    6'b100010: w_ctrl.alucontrol = 3'b110;
                    6'b100100: w_ctrl.alucontrol = 3'b000;
                    6'b100101: w_ctrl.alucontrol = 3'b001;
                    6'b101010: w_ctrl.alucontrol = 3'b111;
                    default:   w_ctrl = '0;   // unknown funct is a NOP
                endcase
            end
            6'b100011: begin   // lw
                w_ctrl.regwrite   = 1'b1;
                w_ctrl.memtoreg   = 1'b1;
                w_ctrl.alusrc     = 1'b1;
                w_ctrl.alucontrol = 3'b010;
            end
            6'b101011: begin   // sw
                w_ctrl.memwrite   = 1'b1;
                w_ctrl.alusrc     = 1'b1;
                w_ctrl.alucontrol = 3'b010;
            end
            6'b000100: begin   // beq
                w_branch          = 1'b1;
                w_ctrl.alucontrol = 3'b110;
            end
            6'b000101: begin   // bne
                w_branch          = 1'b1;
                w_isbne           = 1'b1;
                w_ctrl.alucontrol = 3'b110;
            end
            6'b001000: begin   // addi
                w_ctrl.regwrite   = 1'b1;
                w_ctrl.alusrc     = 1'b1;
                w_ctrl.alucontrol = 3'b010;
            end
            6'b000010: w_jump = 1'b1;
            default:   ;
        endcase
    end

    // ---------------- register file ----------------
    logic [XLEN-1:0]           r_rf [NREG];
    logic [1:0][RB-1:0]        w_raddr;
    logic [1:0][XLEN-1:0]      w_rdata;

    assign w_raddr[0] = w_rsD;
    assign w_raddr[1] = w_rtD;

    // write-through: a same-cycle writeback to the read register wins
    for (genvar p = 0; p < 2; p++) begin : g_rd
        assign w_rdata[p] = (w_raddr[p] == '0) ? '0 :
                            (bus.regwriteW && bus.writeregW == w_raddr[p]) ? bus.resultW :
                            r_rf[w_raddr[p]];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (bus.regwriteW && bus.writeregW != '0) begin
            r_rf[bus.writeregW] <= bus.resultW;
        end
    end

    // ---------------- ID/EX state ----------------
    idex_t           r_ex;
    logic            r_valid;
    logic [CNTW-1:0] r_cnt;

    // ---------------- hazards ----------------
    logic w_memtoregE_int;
    logic w_lwstall;
    logic w_dep_e;
    logic w_dep_m;
    logic w_branchstall;
    logic w_stall;

    assign w_memtoregE_int = r_ex.ctrl.memtoreg & r_valid;
    assign w_lwstall       = w_memtoregE_int && (r_ex.rt == w_rsD || r_ex.rt == w_rtD);
    // branch needs its operands in D: an ALU result still in E, or a load in M,
    // is not yet forwardable
    assign w_dep_e = r_ex.ctrl.regwrite && r_valid && bus.writeregE != '0 &&
                     (bus.writeregE == w_rsD || bus.writeregE == w_rtD);
    assign w_dep_m = bus.memtoregM && bus.writeregM != '0 &&
                     (bus.writeregM == w_rsD || bus.writeregM == w_rtD);
    assign w_branchstall = w_branch && (w_dep_e || w_dep_m);
    assign w_stall       = w_lwstall || w_branchstall;

    // ---------------- branch resolution and targets ----------------
    logic [XLEN-1:0] w_opA;
    logic [XLEN-1:0] w_opB;
    logic            w_eq;

    assign w_opA = (w_rsD != '0 && w_rsD == bus.writeregM && bus.regwriteM) ? bus.aluoutM : w_rdata[0];
    assign w_opB = (w_rtD != '0 && w_rtD == bus.writeregM && bus.regwriteM) ? bus.aluoutM : w_rdata[1];
    assign w_eq  = (w_opA == w_opB);

    assign bus.stallF    = w_stall;
    assign bus.stallD    = w_stall;
    assign bus.pcsrcD    = w_branch && !w_stall && (w_isbne ? !w_eq : w_eq);
    assign bus.jumpD     = w_jump;
    assign bus.pcbranchD = bus.pcplus4D + {w_signimm[XLEN-3:0], 2'b00};
    assign bus.pcjumpD   = {bus.pcplus4D[XLEN-1:28], bus.instrD[25:0], 2'b00};

    // ---------------- ID/EX register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ex    <= '0;
            r_valid <= 1'b0;
        end else if (bus.clr || w_stall) begin
            // bubble: clearing memtoreg here is what ends a load-use stall
            r_ex    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_ex.ctrl <= w_ctrl;
            r_ex.rd1  <= w_rdata[0];
            r_ex.rd2  <= w_rdata[1];
            r_ex.imm  <= w_signimm;
            r_ex.rs   <= w_rsD;
            r_ex.rt   <= w_rtD;
            r_ex.rd   <= w_rdD;
            r_valid   <= 1'b1;
        end
    end

    // ---------------- stall counter ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_stall && r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.validE      = r_valid;
    assign bus.regwriteE   = r_ex.ctrl.regwrite;
    assign bus.memtoregE   = r_ex.ctrl.memtoreg;
    assign bus.memwriteE   = r_ex.ctrl.memwrite;
    assign bus.alusrcE     = r_ex.ctrl.alusrc;
    assign bus.regdstE     = r_ex.ctrl.regdst;
    assign bus.alucontrolE = r_ex.ctrl.alucontrol;
    assign bus.rd1E        = r_ex.rd1;
    assign bus.rd2E        = r_ex.rd2;
    assign bus.signimmE    = r_ex.imm;
    assign bus.rsE         = r_ex.rs;
    assign bus.rtE         = r_ex.rt;
    assign bus.rdE         = r_ex.rd;
    assign bus.stallcount  = r_cnt;

endmodule

// File: tb/tb_decode_stage_hz.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_hz
// Directed bench: a decode table for single-instruction behaviour plus
// hand-written sequences for reset, bypass, load-use, branch forwarding,
// branch stalls and counter saturation (second instance with CNTW=3).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decode_stage_hz;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    decode_stage_hz_if #(.XLEN(32), .NREG(32), .CNTW(16)) b();
    decode_stage_hz_if #(.XLEN(32), .NREG(32), .CNTW(3))  s();

    decode_stage_hz #(.XLEN(32), .NREG(32), .CNTW(16)) u_dut (.clk(clk), .rstn(rstn), .bus(b));
    decode_stage_hz #(.XLEN(32), .NREG(32), .CNTW(3))  u_sat (.clk(clk), .rstn(rstn), .bus(s));

    int checks   = 0;
    int failures = 0;

    logic [7:0] ectrl;
    assign ectrl = {b.regwriteE, b.memtoregE, b.memwriteE, b.alusrcE, b.regdstE, b.alucontrolE};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        exp_jump;
        logic [31:0] exp_pcjump;
        logic [7:0]  exp_ctrl;
        logic [31:0] exp_imm;
        logic [4:0]  exp_rs;
        logic [4:0]  exp_rt;
        logic [4:0]  exp_rd;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int funct);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b.clr = 0; b.instrD = 0; b.pcplus4D = 0;
        b.regwriteW = 0; b.writeregW = 0; b.resultW = 0;
        b.regwriteM = 0; b.memtoregM = 0; b.writeregM = 0; b.aluoutM = 0;
        b.writeregE = 0;
        s.clr = 0; s.instrD = 0; s.pcplus4D = 0;
        s.regwriteW = 0; s.writeregW = 0; s.resultW = 0;
        s.regwriteM = 0; s.memtoregM = 0; s.writeregM = 0; s.aluoutM = 0;
        s.writeregE = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        // ---------------- decode table ----------------
        vt[0]  = '{rtype(3,2,4,32'h20),  32'h0, 1'b0, 32'h0, 8'b10001010, 32'h00002020, 5'd3,  5'd2,  5'd4};
        vt[1]  = '{rtype(5,6,7,32'h22),  32'h0, 1'b0, 32'h0, 8'b10001110, 32'h00003822, 5'd5,  5'd6,  5'd7};
        vt[2]  = '{rtype(1,8,9,32'h24),  32'h0, 1'b0, 32'h0, 8'b10001000, 32'h00004824, 5'd1,  5'd8,  5'd9};
        vt[3]  = '{rtype(11,12,10,32'h25), 32'h0, 1'b0, 32'h0, 8'b10001001, 32'h00005025, 5'd11, 5'd12, 5'd10};
        vt[4]  = '{rtype(14,15,13,32'h2a), 32'h0, 1'b0, 32'h0, 8'b10001111, 32'h0000682a, 5'd14, 5'd15, 5'd13};
        vt[5]  = '{rtype(1,2,3,32'h3f),  32'h0, 1'b0, 32'h0, 8'b00000000, 32'h0000183f, 5'd1,  5'd2,  5'd3};
        vt[6]  = '{itype(32'h2b,7,6,16'hfffc), 32'h0, 1'b0, 32'h0, 8'b00110010, 32'hfffffffc, 5'd7, 5'd6, 5'd31};
        vt[7]  = '{itype(32'h08,9,8,16'h7fff), 32'h0, 1'b0, 32'h0, 8'b10010010, 32'h00007fff, 5'd9, 5'd8, 5'd15};
        vt[8]  = '{{6'h02, 26'h0123456}, 32'ha0000004, 1'b1, 32'ha048d158, 8'b00000000, 32'h00003456, 5'd0, 5'd18, 5'd6};
        vt[9]  = '{itype(32'h3f,1,2,16'h1234), 32'h0, 1'b0, 32'h0, 8'b00000000, 32'h00001234, 5'd1, 5'd2, 5'd2};
        vt[10] = '{itype(32'h23,3,2,16'h0008), 32'h0, 1'b0, 32'h0, 8'b11010010, 32'h00000008, 5'd3, 5'd2, 5'd0};

        // ---------------- reset with random inputs ----------------
        idle_inputs();
        b.instrD = $urandom; b.pcplus4D = $urandom;
        b.regwriteW = 1'b1; b.writeregW = 5'($urandom); b.resultW = $urandom;
        b.regwriteM = 1'($urandom); b.writeregM = 5'($urandom); b.aluoutM = $urandom;
        tick(); tick();
        chk("rst_valid", b.validE, 0);
        chk("rst_ctrl", ectrl, 0);
        chk("rst_rd1", b.rd1E, 0);
        chk("rst_rd2", b.rd2E, 0);
        chk("rst_imm", b.signimmE, 0);
        chk("rst_fields", {b.rsE, b.rtE, b.rdE}, 0);
        chk("rst_cnt", b.stallcount, 0);
        // combinational outputs keep working while reset is held
        b.instrD = {6'h02, 26'h0123456}; b.pcplus4D = 32'ha0000004;
        #1;
        chk("rst_jump", b.jumpD, 1);
        chk("rst_pcjump", b.pcjumpD, 32'ha048d158);
        idle_inputs();
        rstn = 1'b1;
        b.instrD = rtype(5,0,6,32'h20);
        tick();
        chk("rel_valid", b.validE, 1);
        chk("rel_rd1", b.rd1E, 0);
        chk("rel_rs", b.rsE, 5);

        // ---------------- writeback bypass ----------------
        b.regwriteW = 1; b.writeregW = 3; b.resultW = 32'ha5;
        b.instrD = rtype(3,0,4,32'h20);
        tick();
        chk("byp_rd1", b.rd1E, 32'ha5);
        chk("byp_valid", b.validE, 1);
        b.regwriteW = 0;
        b.instrD = rtype(0,3,4,32'h20);
        tick();
        chk("byp_stored_rd2", b.rd2E, 32'ha5);
        b.regwriteW = 1; b.writeregW = 0; b.resultW = 32'hffffffff;
        b.instrD = rtype(0,0,4,32'h20);
        tick();
        chk("r0_byp_rd1", b.rd1E, 0);
        chk("r0_byp_rd2", b.rd2E, 0);
        b.regwriteW = 0;
        tick();
        chk("r0_stored", b.rd1E, 0);

        // ---------------- decode table ----------------
        do_reset();
        for (int i = 0; i < 11; i++) begin
            b.instrD = vt[i].instr; b.pcplus4D = vt[i].pc4;
            #1;
            chk("tbl_stall", b.stallD, 0);
            chk("tbl_jump", b.jumpD, vt[i].exp_jump);
            if (vt[i].exp_jump) chk("tbl_pcjump", b.pcjumpD, vt[i].exp_pcjump);
            tick();
            chk("tbl_valid", b.validE, 1);
            chk("tbl_ctrl", ectrl, vt[i].exp_ctrl);
            chk("tbl_imm", b.signimmE, vt[i].exp_imm);
            chk("tbl_fields", {b.rsE, b.rtE, b.rdE}, {vt[i].exp_rs, vt[i].exp_rt, vt[i].exp_rd});
            chk("tbl_rd1", b.rd1E, 0);
        end

        // ---------------- load-use ----------------
        do_reset();
        b.instrD = itype(32'h23,1,2,16'h0000);
        tick();
        chk("lu_memtoregE", b.memtoregE, 1);
        b.instrD = rtype(2,1,5,32'h20);
        #1;
        chk("lu_stallD", b.stallD, 1);
        chk("lu_stallF", b.stallF, 1);
        tick();
        chk("lu_bubble", b.validE, 0);
        chk("lu_cnt1", b.stallcount, 1);
        chk("lu_released", b.stallD, 0);
        tick();
        chk("lu_issue_valid", b.validE, 1);
        chk("lu_issue_rs", b.rsE, 2);
        chk("lu_issue_regdst", b.regdstE, 1);
        chk("lu_cnt_hold", b.stallcount, 1);

        // ---------------- branch operand forwarding ----------------
        do_reset();
        b.regwriteW = 1; b.writeregW = 1; b.resultW = 7;
        tick();
        b.regwriteW = 0;
        b.regwriteM = 1; b.writeregM = 2; b.aluoutM = 7;
        b.instrD = itype(4,1,2,16'h0004); b.pcplus4D = 32'h100;
        #1;
        chk("fwd_beq_pcsrc", b.pcsrcD, 1);
        chk("fwd_pcbranch", b.pcbranchD, 32'h110);
        chk("fwd_nostall", b.stallD, 0);
        b.instrD = itype(5,1,2,16'h0004);
        #1;
        chk("fwd_bne_pcsrc", b.pcsrcD, 0);
        b.regwriteM = 0;
        #1;
        chk("nofwd_bne_pcsrc", b.pcsrcD, 1);
        b.instrD = itype(4,1,2,16'h0004);
        #1;
        chk("nofwd_beq_pcsrc", b.pcsrcD, 0);
        b.instrD = itype(4,0,0,16'hffff); b.pcplus4D = 32'h200;
        #1;
        chk("neg_pcbranch", b.pcbranchD, 32'h1fc);
        chk("r0_beq_pcsrc", b.pcsrcD, 1);
        // load in M feeding the branch
        b.memtoregM = 1; b.writeregM = 2;
        b.instrD = itype(4,2,0,16'h0001);
        #1;
        chk("ldM_stall", b.stallD, 1);
        chk("ldM_pcsrc", b.pcsrcD, 0);

        // ---------------- branch stall with clr ----------------
        do_reset();
        b.instrD = rtype(3,4,2,32'h20);
        tick();
        b.writeregE = 2;
        b.instrD = itype(4,2,0,16'h0001);
        #1;
        chk("bs_stall", b.stallD, 1);
        chk("bs_pcsrc", b.pcsrcD, 0);
        b.clr = 1;
        tick();
        chk("bs_bubble", b.validE, 0);
        chk("bs_bubble_rw", b.regwriteE, 0);
        chk("bs_cnt", b.stallcount, 1);
        b.clr = 0;
        #1;
        chk("bs_released", b.stallD, 0);
        chk("bs_taken", b.pcsrcD, 1);
        tick();
        // clr alone: bubble without counting
        b.writeregE = 0;
        b.instrD = rtype(3,4,2,32'h20);
        b.clr = 1;
        #1;
        chk("clr_nostall", b.stallD, 0);
        tick();
        chk("clr_bubble", b.validE, 0);
        chk("clr_cnt", b.stallcount, 1);
        b.clr = 0;
        // load in E feeding a branch: stalls in E then again in M
        b.instrD = itype(32'h23,1,2,16'h0000);
        tick();
        b.writeregE = 2;
        b.instrD = itype(4,2,0,16'h0001);
        #1;
        chk("ldE_stall1", b.stallD, 1);
        tick();
        chk("ldE_bubble", b.validE, 0);
        b.writeregE = 0; b.memtoregM = 1; b.writeregM = 2;
        #1;
        chk("ldE_stall2", b.stallD, 1);
        tick();
        b.memtoregM = 0; b.writeregM = 0;
        #1;
        chk("ldE_released", b.stallD, 0);
        chk("ldE_cnt", b.stallcount, 3);

        // ---------------- stall counter saturation (CNTW=3) ----------------
        do_reset();
        s.memtoregM = 1; s.writeregM = 2;
        s.instrD = itype(4,2,0,16'h0001);
        #1;
        chk("sat_stall", s.stallD, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("sat_cnt", s.stallcount, (i + 1 < 7) ? i + 1 : 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Parametrised decode stage for the 5-stage MIPS-subset pipeline, the successor to the fixed 32-bit decode stage. It holds the register file, the main control decoder, branch/jump target generation and the ID/EX pipeline register. It also has features the earlier stage lacked:

- internal hazard detection (load-use and branch-dependency stalls);
- internal branch-operand forwarding;
- beq/bne support;
- a valid bit on the ID/EX register;
- a saturating stall counter.

It sits between the IF/ID register and the execute stage.

## Interface
Parameters:
- XLEN, 32, datapath width (≥32; immediates sign-extend to XLEN).
- NREG, 32, number of architectural registers (power of 2, ≥8); RB = $clog2(NREG).
- CNTW, 16, width of the stall counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush of ID/EX (turns the next E slot into a bubble).
- instrD  in  32  instruction in decode.
- pcplus4D  in  XLEN  PC+4 of instrD.
- regwriteW  in  1  writeback enable.
- writeregW  in  RB  writeback register.
- resultW  in  XLEN  writeback data.
- regwriteM, memtoregM  in  1  memory-stage control.
- writeregM  in  RB  memory-stage destination.
- aluoutM  in  XLEN  memory-stage ALU result.
- writeregE  in  RB  execute-stage destination (muxed rt/rd from execute).
- stallF, stallD  out  1  hold the PC and IF/ID.
- pcsrcD, jumpD  out  1  redirect requests.
- pcbranchD, pcjumpD  out  XLEN  branch and jump targets.
- validE, regwriteE, memtoregE, memwriteE, alusrcE, regdstE  out  1  ID/EX control.
- alucontrolE  out  3  ALU op.
- rd1E, rd2E, signimmE  out  XLEN  ID/EX data.
- rsE, rtE, rdE  out  RB  ID/EX register fields.
- stallcount  out  CNTW  saturating count of stall cycles.

## Operation
**Register fields**
- rsD = instrD[25:21], rtD = instrD[20:16] and rdD = instrD[15:11].
- Fields are zero-extended or truncated to RB bits.

**Decode**
- Opcodes: R-type 000000 (funct add 100000, sub 100010, and 100100, or 100101, slt 101010), lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
- alucontrol values: add 010, sub 110, and 000, or 001, slt 111.
- Unknown opcode or funct decodes to all-zero control (a NOP).

**Register file**
- NREG×XLEN registers, all cleared by rstn.
- Write on the rising edge when regwriteW && writeregW≠0.
- Register 0 always reads 0.
- Same-cycle read of writeregW (≠0, regwriteW=1) returns resultW (write-through bypass).

**Branch operands**
- Operand A is aluoutM if rsD≠0 && rsD==writeregM && regwriteM, else the regfile value.
- Operand B uses the same rule on rtD.
- beq: pcsrcD = (A==B).
- bne: pcsrcD = (A≠B).
- pcsrcD is forced to 0 while stallD=1.

**Targets**
- pcbranchD = pcplus4D + (signimm<<2), mod 2^XLEN.
- pcjumpD = {pcplus4D[XLEN-1:28], instrD[25:0], 2'b00}.
- jumpD is asserted for j.

**Hazards** (all combinational)
- lwstall = memtoregE_int && (rtE==rsD || rtE==rtD), where memtoregE_int is the registered memtoregE qualified by validE.
- branchstall = branchD && ((regwriteE && validE && writeregE≠0 && (writeregE==rsD || writeregE==rtD)) || (memtoregM && writeregM≠0 && (writeregM==rsD || writeregM==rtD))).
- stallF = stallD = lwstall || branchstall.

**ID/EX register**
- Update priority: rstn=0, then clr, then stallD, then normal.
- Bubble on clr or stallD:
  - validE and all E control outputs go to 0.
  - Data and register fields go to 0.
- Normal: capture decoded control, rd1/rd2 (with bypass), sign-extended immediate and rs/rt/rd; validE=1.

**Stall counter**
- Increments each cycle stallD=1.
- Saturates at 2^CNTW−1.
- Cleared only by rstn.

## Timing
- Reset (asynchronous, immediate): all ID/EX outputs 0, validE=0, stallcount=0, register file all 0.
- Combinational outputs reflect inputs during reset: stallF/stallD/pcsrcD/jumpD/pcbranchD/pcjumpD.
- Decode→execute latency: 1 cycle.
- Register write→read latency: 0 cycles (bypass).
- A load-use stall lasts exactly 1 cycle: the bubble clears memtoregE_int.
- A branch stall lasts 1 cycle for an ALU producer in E and 1 cycle for a load in M.
  - A load in E that the branch depends on gives 2 cycles: E, then M.
- Simultaneous clr and stallD: bubble; the counter still increments.
- Deassertion of rstn mid-operation resumes normally on the next edge.

## Test plan
- Reset: rstn=0 with random inputs → all registered outputs 0; after release, reading $5 gives 0.
- Writeback bypass: regwriteW=1, writeregW=3, resultW=0xA5; instrD=add $4,$3,$0 in the same cycle → next edge rd1E=0xA5 and validE=1. Write to $0 → reads stay 0.
- Load-use: lw $2 captured into E, then instrD=add $5,$2,$1 → stallD=1 for 1 cycle, validE=0 next edge, add issues the cycle after, stallcount=1.
- Branch forwarding: $1=7; regwriteM=1, writeregM=2, aluoutM=7; beq $1,$2,+4 with pcplus4D=0x100 → pcsrcD=1, pcbranchD=0x110. The same operands with bne → pcsrcD=0.
- Branch stall: add $2 valid in E, then beq $2,$0 in D → stallD=1 and pcsrcD=0 that cycle. With clr asserted as well → bubble.
- Saturation: CNTW=3, stallD held 10 cycles → stallcount stops at 7.
